// File: rtl/usbdev_resume_tx_pkg.sv
// usbdev_resume_tx_pkg
//   Shared types and line-state helpers for the device-side remote-wakeup
//   resume generator (usbdev_resume_tx).
//   - resume_status_e   : outcome of a resume sequence, reported on status_o
//   - resume_tx_state_e : FSM state encoding, exposed on the dbg_state port
//   - line_is_j / line_is_se0 : bus line decoders that honour pin flip

package usbdev_resume_tx_pkg;

    typedef enum logic [1:0] {
        ResumeOk       = 2'd0,
        ResumeHostWake = 2'd1,
        ResumeAborted  = 2'd2
    } resume_status_e;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StWaitIdle = 3'd1,
        StDriveK   = 3'd2,
        StRelease  = 3'd3,
        StDone     = 3'd4
    } resume_tx_state_e;

    // J is the idle state: each line sits at the level its pull-up selects.
    // Using the pull-up selects keeps this correct when D+/D- are flipped.
    function automatic logic line_is_j(
        input logic dp,
        input logic dn,
        input logic dp_pullup,
        input logic dn_pullup
    );
        return (dp == dp_pullup) && (dn == dn_pullup);
    endfunction

    function automatic logic line_is_se0(
        input logic dp,
        input logic dn
    );
        return !dp && !dn;
    endfunction

endpackage

// File: rtl/usbdev_resume_tx.sv
// usbdev_resume_tx
//   Remote-wakeup resume signalling generator, AON clock domain.
//   On a wake request while the link is suspended it waits for the bus to be
//   idle (J) for IdleCycles consecutive cycles, drives K for ResumeCycles
//   cycles, releases the bus for one cycle with the data values still at K,
//   then reports the outcome and waits for the request to drop.
//
// Ports:
//   clk_aon_i          in  AON clock (~200 kHz)
//   rst_aon_i          in  synchronous active-high reset
//   enable_i           in  link suspended and wake detector active
//   wake_req_i         in  level remote-wakeup request
//   usb_sense_i        in  VBUS sense
//   usb_dp_i/usb_dn_i  in  synchronized bus line levels
//   usb_dppullup_en_i  in  D+ pull-up selected (defines J, covers pin flip)
//   usb_dnpullup_en_i  in  D- pull-up selected
//   usb_d_oe_o         out D+/D- drive enable, high only in DriveK
//   usb_dp_o/usb_dn_o  out driven line values (K during DriveK and Release)
//   busy_o             out sequence in progress (WaitIdle, DriveK, Release)
//   done_o             out sequence finished, status_o valid
//   status_o           out resume_status_e outcome
//   dbg_state          out current FSM state (resume_tx_state_e encoding)
//
// Request/done handshake: wake_req_i is a level request sampled only in Idle.
// Once a sequence starts it runs to completion regardless of wake_req_i.
// done_o rises when the sequence ends and stays high, with status_o stable,
// until wake_req_i is seen low; the FSM then returns to Idle and done_o falls
// on that same edge.

module usbdev_resume_tx
    import usbdev_resume_tx_pkg::*;
#(
    parameter int IdleCycles   = 400,
    parameter int ResumeCycles = 400,
    parameter int CntMax       = (IdleCycles > ResumeCycles) ? IdleCycles : ResumeCycles,
    parameter int CntW         = (CntMax > 1) ? $clog2(CntMax) : 1
) (
    input  logic       clk_aon_i,
    input  logic       rst_aon_i,
    input  logic       enable_i,
    input  logic       wake_req_i,
    input  logic       usb_sense_i,
    input  logic       usb_dp_i,
    input  logic       usb_dn_i,
    input  logic       usb_dppullup_en_i,
    input  logic       usb_dnpullup_en_i,
    output logic       usb_d_oe_o,
    output logic       usb_dp_o,
    output logic       usb_dn_o,
    output logic       busy_o,
    output logic       done_o,
    output logic [1:0] status_o,
    output logic [2:0] dbg_state
);

    localparam logic [CntW-1:0] IdleLast   = CntW'(IdleCycles - 1);
    localparam logic [CntW-1:0] ResumeLast = CntW'(ResumeCycles - 1);

    resume_tx_state_e state_q, state_d;
    resume_status_e   status_q, status_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    logic is_j;
    logic is_se0;
    logic abort;
    logic start;

    assign is_j   = line_is_j(usb_dp_i, usb_dn_i, usb_dppullup_en_i, usb_dnpullup_en_i);
    assign is_se0 = line_is_se0(usb_dp_i, usb_dn_i);
    assign abort  = !enable_i || !usb_sense_i;
    assign start  = enable_i && wake_req_i && usb_sense_i;

    // Next-state logic. Abort is checked first in every active state so it
    // wins over any terminal-count or line-state transition in the same cycle.
    // Every terminal compare leaves its state, so the counter never wraps.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        status_d = status_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StWaitIdle;
                    cnt_d   = '0;
                end
            end

            StWaitIdle: begin
                if (abort) begin
                    state_d  = StDone;
                    status_d = ResumeAborted;
                    cnt_d    = '0;
                end else if (is_j) begin
                    if (cnt_q == IdleLast) begin
                        state_d = StDriveK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end else if (is_se0) begin
                    // SE0 breaks the idle run; the J count starts over.
                    cnt_d = '0;
                end else begin
                    // K on the bus: the host is already resuming.
                    state_d  = StDone;
                    status_d = ResumeHostWake;
                    cnt_d    = '0;
                end
            end

            StDriveK: begin
                if (abort) begin
                    state_d  = StDone;
                    status_d = ResumeAborted;
                    cnt_d    = '0;
                end else if (cnt_q == ResumeLast) begin
                    state_d = StRelease;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end

            StRelease: begin
                state_d  = StDone;
                status_d = abort ? ResumeAborted : ResumeOk;
                cnt_d    = '0;
            end

            StDone: begin
                if (!wake_req_i) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and all outputs are registered; outputs are decoded from
    // the next state so they change on the same edge as the state.
    // During Release the data values stay at K while the enable drops, so the
    // pad never sees a transient driven J/SE0 as it lets go of the bus.
    always_ff @(posedge clk_aon_i) begin
        if (rst_aon_i) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            status_q   <= ResumeOk;
            usb_d_oe_o <= 1'b0;
            usb_dp_o   <= 1'b0;
            usb_dn_o   <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            status_q   <= status_d;
            usb_d_oe_o <= (state_d == StDriveK);
            if ((state_d == StDriveK) || (state_d == StRelease)) begin
                usb_dp_o <= usb_dnpullup_en_i;
                usb_dn_o <= usb_dppullup_en_i;
            end else begin
                usb_dp_o <= 1'b0;
                usb_dn_o <= 1'b0;
            end
            busy_o <= (state_d == StWaitIdle) || (state_d == StDriveK) ||
                      (state_d == StRelease);
            done_o <= (state_d == StDone);
        end
    end

    assign status_o  = status_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_usbdev_resume_tx.sv
// tb_usbdev_resume_tx
//   Directed bench for usbdev_resume_tx with IdleCycles=8, ResumeCycles=6.
//   Inputs are driven and outputs sampled 1 time unit after each rising edge.
//   "Edge n" counts rising edges after the start condition is presented.

module tb_usbdev_resume_tx;

    localparam int IdleCycles   = 8;
    localparam int ResumeCycles = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       wake_req = 1'b0;
    logic       sense = 1'b0;
    logic       dp_in = 1'b1;
    logic       dn_in = 1'b0;
    logic       dp_pu = 1'b1;
    logic       dn_pu = 1'b0;
    logic       d_oe;
    logic       dp_out;
    logic       dn_out;
    logic       busy;
    logic       done;
    logic [1:0] status;
    logic [2:0] dbg_state;

    int checks = 0;
    int errors = 0;

    usbdev_resume_tx #(
        .IdleCycles   (IdleCycles),
        .ResumeCycles (ResumeCycles)
    ) dut (
        .clk_aon_i         (clk),
        .rst_aon_i         (rst),
        .enable_i          (enable),
        .wake_req_i        (wake_req),
        .usb_sense_i       (sense),
        .usb_dp_i          (dp_in),
        .usb_dn_i          (dn_in),
        .usb_dppullup_en_i (dp_pu),
        .usb_dnpullup_en_i (dn_pu),
        .usb_d_oe_o        (d_oe),
        .usb_dp_o          (dp_out),
        .usb_dn_o          (dn_out),
        .busy_o            (busy),
        .done_o            (done),
        .status_o          (status),
        .dbg_state         (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // driver tasks
    task automatic set_j();
        dp_in = dp_pu;
        dn_in = dn_pu;
    endtask

    task automatic set_k();
        dp_in = dn_pu;
        dn_in = dp_pu;
    endtask

    task automatic set_se0();
        dp_in = 1'b0;
        dn_in = 1'b0;
    endtask

    // Presents the start condition and advances to edge 1.
    task automatic start_seq(input logic hold_req);
        enable   = 1'b1;
        sense    = 1'b1;
        wake_req = 1'b1;
        tick();
        if (!hold_req) wake_req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({d_oe, dp_out, dn_out, busy, done, status} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs: got oe=%b dp=%b dn=%b busy=%b done=%b status=%0d, want all 0",
                     d_oe, dp_out, dn_out, busy, done, status);
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({busy, done, d_oe} !== 3'b000) begin
            errors++;
            $display("FAIL reset_idle: got busy/done/oe=%b, want 000", {busy, done, d_oe});
        end
    endtask

    task automatic test_no_start();
        set_j();
        enable = 1'b1; sense = 1'b0; wake_req = 1'b1;
        tick(); tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL no_start_sense: got busy=%b, want 0", busy);
        end
        enable = 1'b0; sense = 1'b1;
        tick(); tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL no_start_enable: got busy=%b, want 0", busy);
        end
        enable = 1'b1; wake_req = 1'b0;
        tick(); tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL no_start_req: got busy=%b, want 0", busy);
        end
    endtask

    // Full sequence with bus J throughout; flip swaps the pull-up selects.
    task automatic test_normal(input logic flip);
        logic exp_busy, exp_oe, exp_done;
        dp_pu = !flip;
        dn_pu = flip;
        set_j();
        start_seq(1'b0);
        checks++;
        if ({busy, d_oe, done} !== 3'b100) begin
            errors++;
            $display("FAIL normal_edge1 flip=%b: got busy/oe/done=%b, want 100", flip, {busy, d_oe, done});
        end
        for (int e = 2; e <= 16; e++) begin
            tick();
            exp_oe   = (e >= 9) && (e <= 14);
            exp_busy = (e <= 15);
            exp_done = (e == 16);
            checks++;
            if ({busy, d_oe, done} !== {exp_busy, exp_oe, exp_done}) begin
                errors++;
                $display("FAIL normal_edge%0d flip=%b: got busy/oe/done=%b, want %b",
                         e, flip, {busy, d_oe, done}, {exp_busy, exp_oe, exp_done});
            end
            if (e == 9 || e == 15) begin
                // K: D+ takes the D- pull-up select and vice versa.
                checks++;
                if ({dp_out, dn_out} !== {flip, !flip}) begin
                    errors++;
                    $display("FAIL normal_k_values edge%0d flip=%b: got dp/dn=%b, want %b",
                             e, flip, {dp_out, dn_out}, {flip, !flip});
                end
            end
            if (e == 16) begin
                checks++;
                if (status !== 2'd0) begin
                    errors++;
                    $display("FAIL normal_status flip=%b: got %0d, want 0", flip, status);
                end
            end
        end
        tick();
        checks++;
        if ({busy, d_oe, done} !== 3'b000) begin
            errors++;
            $display("FAIL normal_back_idle flip=%b: got busy/oe/done=%b, want 000", flip, {busy, d_oe, done});
        end
        dp_pu = 1'b1;
        dn_pu = 1'b0;
        set_j();
    endtask

    task automatic test_se0_restart();
        set_j();
        start_seq(1'b0);
        for (int e = 2; e <= 6; e++) tick();
        set_se0();
        for (int e = 7; e <= 9; e++) begin
            tick();
            checks++;
            if ({busy, d_oe} !== 2'b10) begin
                errors++;
                $display("FAIL se0_hold edge%0d: got busy/oe=%b, want 10", e, {busy, d_oe});
            end
        end
        set_j();
        for (int e = 10; e <= 16; e++) tick();
        checks++;
        if (d_oe !== 1'b0) begin
            errors++;
            $display("FAIL se0_no_early_k: got oe=%b at 7th J cycle, want 0", d_oe);
        end
        tick();
        checks++;
        if (d_oe !== 1'b1) begin
            errors++;
            $display("FAIL se0_k_after_8j: got oe=%b, want 1", d_oe);
        end
        // Abort via enable; outputs flip on one edge.
        enable = 1'b0;
        tick();
        checks++;
        if ({d_oe, busy, done, status} !== {3'b001, 2'd2}) begin
            errors++;
            $display("FAIL enable_abort: got oe/busy/done=%b status=%0d, want 001 status 2",
                     {d_oe, busy, done}, status);
        end
        enable = 1'b1;
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL enable_abort_release: got done=%b, want 0", done);
        end
    endtask

    task automatic test_host_wake();
        logic saw_oe;
        saw_oe = 1'b0;
        set_j();
        start_seq(1'b0);
        saw_oe = saw_oe | d_oe;
        tick(); saw_oe = saw_oe | d_oe;
        tick(); saw_oe = saw_oe | d_oe;
        set_k();
        tick(); saw_oe = saw_oe | d_oe;
        checks++;
        if ({done, busy, status} !== {2'b10, 2'd1}) begin
            errors++;
            $display("FAIL host_wake: got done/busy=%b status=%0d, want 10 status 1", {done, busy}, status);
        end
        checks++;
        if (saw_oe !== 1'b0) begin
            errors++;
            $display("FAIL host_wake_no_drive: got oe seen=%b, want 0", saw_oe);
        end
        set_j();
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL host_wake_release: got done=%b, want 0", done);
        end
    endtask

    task automatic test_sense_abort();
        set_j();
        start_seq(1'b1);
        for (int e = 2; e <= 9; e++) tick();
        checks++;
        if (d_oe !== 1'b1) begin
            errors++;
            $display("FAIL sense_abort_drivek: got oe=%b, want 1", d_oe);
        end
        tick(); tick();
        sense = 1'b0;
        tick();
        checks++;
        if ({d_oe, busy, done, status} !== {3'b001, 2'd2}) begin
            errors++;
            $display("FAIL sense_abort: got oe/busy/done=%b status=%0d, want 001 status 2",
                     {d_oe, busy, done}, status);
        end
        tick(); tick();
        checks++;
        if ({done, status} !== {1'b1, 2'd2}) begin
            errors++;
            $display("FAIL sense_abort_hold: got done=%b status=%0d, want 1 status 2", done, status);
        end
        wake_req = 1'b0;
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL sense_abort_release: got done=%b, want 0", done);
        end
        sense = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_drivek();
        set_j();
        start_seq(1'b0);
        for (int e = 2; e <= 11; e++) tick();
        checks++;
        if (d_oe !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_drivek_pre: got oe=%b, want 1", d_oe);
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({d_oe, dp_out, dn_out, busy, done, status} !== 7'b0) begin
            errors++;
            $display("FAIL rst_mid_drivek: got oe=%b dp=%b dn=%b busy=%b done=%b status=%0d, want all 0",
                     d_oe, dp_out, dn_out, busy, done, status);
        end
        rst = 1'b0;
        for (int e = 0; e < 4; e++) begin
            tick();
            checks++;
            if ({busy, d_oe, done} !== 3'b000) begin
                errors++;
                $display("FAIL rst_no_restart cycle%0d: got busy/oe/done=%b, want 000", e, {busy, d_oe, done});
            end
        end
    endtask

    initial begin
        test_reset();
        test_no_start();
        test_normal(1'b0);
        test_normal(1'b1);
        test_se0_restart();
        test_host_wake();
        test_sense_abort();
        test_reset_mid_drivek();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
